tag_array_ctrl: RTL and testbench

Single-clock sequencer and port scheduler for the 64-set x 8-way x 23-bit tag array (`tag_array_64x184`). It clears every set after reset and on a flush request. It arbitrates a lookup requester onto the read port and an update requester onto the masked write port, and stalls same-set lookups behind in-flight writes. It sits between the cache pipeline and the tag array macro. It drives both macro clocks from `clock`.

---
 rtl/tag_array_ctrl.sv | 148 ++++++++++++++
 tb/tb_tag_array_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tag_array_ctrl.sv
// tag_array_ctrl
//   Sequencer and port scheduler for the 64-set x 8-way x 23-bit tag array.
//   Clears every set after reset and on flush, schedules lookups onto the
//   read port and single-way updates onto the masked write port, and holds
//   off a lookup that targets the set being written in the same cycle.
//
//   Ports:
//     clock, reset_n            single clock, synchronous active-low reset
//     lookup_*                  lookup request (valid/ready) and set index
//     resp_valid, resp_data     one-cycle response pulse with the full row
//     upd_*                     tag-write request: set, way, tag
//     flush_req, busy,          clear-array request, clear in progress,
//     flush_done                clear-complete pulse
//     mem_r_*, mem_w_*          tag array macro read and masked-write ports
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_CLEAR | writing zeros to set cnt_q each cycle, no requests accepted
//   ST_RUN   | arbitrating lookups and updates onto the macro ports
module tag_array_ctrl #(
  parameter  int SETS  = 64,
  parameter  int WAYS  = 8,
  parameter  int TAG_W = 23,
  localparam int IDX_W = $clog2(SETS),
  localparam int WAY_W = $clog2(WAYS),
  localparam int ROW_W = WAYS * TAG_W
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             lookup_valid,
  output logic             lookup_ready,
  input  logic [IDX_W-1:0] lookup_set,
  output logic             resp_valid,
  output logic [ROW_W-1:0] resp_data,
  input  logic             upd_valid,
  output logic             upd_ready,
  input  logic [IDX_W-1:0] upd_set,
  input  logic [WAY_W-1:0] upd_way,
  input  logic [TAG_W-1:0] upd_tag,
  input  logic             flush_req,
  output logic             busy,
  output logic             flush_done,
  output logic             mem_r_en,
  output logic [IDX_W-1:0] mem_r_addr,
  input  logic [ROW_W-1:0] mem_r_data,
  output logic             mem_w_en,
  output logic [IDX_W-1:0] mem_w_addr,
  output logic [ROW_W-1:0] mem_w_data,
  output logic [WAYS-1:0]  mem_w_mask
);

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             flush_done_q, flush_done_d;
  logic             resp_valid_q, resp_valid_d;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    busy_d       = busy_q;
    flush_done_d = 1'b0;
    resp_valid_d = 1'b0;
    lookup_ready = 1'b0;
    upd_ready    = 1'b0;
    mem_r_en     = 1'b0;
    mem_r_addr   = '0;
    mem_w_en     = 1'b0;
    mem_w_addr   = '0;
    mem_w_data   = '0;
    mem_w_mask   = '0;

    case (state_q)
      ST_CLEAR: begin
        mem_w_en   = 1'b1;
        mem_w_addr = cnt_q;
        mem_w_mask = '1;
        cnt_d      = cnt_q + 1'b1;
        if (cnt_q == IDX_W'(SETS - 1)) begin
          state_d      = ST_RUN;
          busy_d       = 1'b0;
          flush_done_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (flush_req) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end else begin
          upd_ready = 1'b1;
          // Read-during-write to one set is undefined in the macro, so the
          // lookup waits one cycle and then sees the written row.
          lookup_ready = !(upd_valid && (upd_set == lookup_set));
          if (upd_valid) begin
            mem_w_en   = 1'b1;
            mem_w_addr = upd_set;
            mem_w_data = {WAYS{upd_tag}};
            mem_w_mask = WAYS'(1) << upd_way;
          end
          if (lookup_valid && lookup_ready) begin
            mem_r_en     = 1'b1;
            mem_r_addr   = lookup_set;
            resp_valid_d = 1'b1;
          end
        end
      end
    endcase

    // Keep the macro idle and requesters stalled while reset is asserted.
    if (!reset_n) begin
      lookup_ready = 1'b0;
      upd_ready    = 1'b0;
      mem_r_en     = 1'b0;
      mem_r_addr   = '0;
      mem_w_en     = 1'b0;
      mem_w_addr   = '0;
      mem_w_data   = '0;
      mem_w_mask   = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= ST_CLEAR;
      cnt_q        <= '0;
      busy_q       <= 1'b1;
      flush_done_q <= 1'b0;
      resp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      busy_q       <= busy_d;
      flush_done_q <= flush_done_d;
      resp_valid_q <= resp_valid_d;
    end
  end

  assign busy       = busy_q;
  assign flush_done = flush_done_q;
  assign resp_valid = resp_valid_q;
  // The macro's read data arrives one cycle after R0_en; mask it outside
  // the response pulse so the port stays quiet.
  assign resp_data  = resp_valid_q ? mem_r_data : '0;

endmodule

// File: tb/tb_tag_array_ctrl.sv
module tb_tag_array_ctrl;

  logic         clock = 1'b0;
  logic         reset_n;
  logic         lookup_valid;
  logic         lookup_ready;
  logic [5:0]   lookup_set;
  logic         resp_valid;
  logic [183:0] resp_data;
  logic         upd_valid;
  logic         upd_ready;
  logic [5:0]   upd_set;
  logic [2:0]   upd_way;
  logic [22:0]  upd_tag;
  logic         flush_req;
  logic         busy;
  logic         flush_done;
  logic         mem_r_en;
  logic [5:0]   mem_r_addr;
  logic [183:0] mem_r_data;
  logic         mem_w_en;
  logic [5:0]   mem_w_addr;
  logic [183:0] mem_w_data;
  logic [7:0]   mem_w_mask;

  always #5 clock = ~clock;

  tag_array_ctrl dut (
    .clock(clock), .reset_n(reset_n),
    .lookup_valid(lookup_valid), .lookup_ready(lookup_ready), .lookup_set(lookup_set),
    .resp_valid(resp_valid), .resp_data(resp_data),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_set(upd_set),
    .upd_way(upd_way), .upd_tag(upd_tag),
    .flush_req(flush_req), .busy(busy), .flush_done(flush_done),
    .mem_r_en(mem_r_en), .mem_r_addr(mem_r_addr), .mem_r_data(mem_r_data),
    .mem_w_en(mem_w_en), .mem_w_addr(mem_w_addr), .mem_w_data(mem_w_data),
    .mem_w_mask(mem_w_mask)
  );

  // Tag array macro: synchronous read (old data on same-edge write), masked write.
  logic [183:0] arr [64];
  logic         seeded = 1'b0;
  always @(posedge clock) begin
    if (!seeded) begin
      for (int i = 0; i < 64; i++)
        for (int w = 0; w < 8; w++) arr[i][w*23 +: 23] <= 23'($urandom);
      seeded <= 1'b1;
    end else begin
      if (mem_r_en) mem_r_data <= arr[mem_r_addr];
      if (mem_w_en)
        for (int w = 0; w < 8; w++)
          if (mem_w_mask[w]) arr[mem_w_addr][w*23 +: 23] <= mem_w_data[w*23 +: 23];
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [183:0] got, input logic [183:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: tag contents per set/way plus the sequencing rules.
  logic [22:0]  exp_mem [64][8];
  int           clr_idx   = -1;   // next set to clear, -1 when running
  bit           model_ok  = 0;
  bit           done_pend = 0;
  bit           resp_pend = 0;
  logic [183:0] resp_row;
  bit           lk_acc    = 0;
  logic [183:0] last_resp;

  function automatic logic [183:0] exp_row(input int s);
    logic [183:0] r;
    for (int w = 0; w < 8; w++) r[w*23 +: 23] = exp_mem[s][w];
    return r;
  endfunction

  task automatic check_cycle();
    bit up_acc, lk_rdy;
    if (!reset_n) begin
      check_eq("rst_busy",  busy, 1);
      check_eq("rst_done",  flush_done, 0);
      check_eq("rst_rvld",  resp_valid, 0);
      check_eq("rst_rdata", resp_data, 0);
      check_eq("rst_lrdy",  lookup_ready, 0);
      check_eq("rst_urdy",  upd_ready, 0);
      check_eq("rst_ren",   mem_r_en, 0);
      check_eq("rst_raddr", mem_r_addr, 0);
      check_eq("rst_wen",   mem_w_en, 0);
      check_eq("rst_waddr", mem_w_addr, 0);
      check_eq("rst_wdata", mem_w_data, 0);
      check_eq("rst_wmask", mem_w_mask, 0);
      return;
    end
    check_eq("busy", busy, clr_idx >= 0);
    check_eq("flush_done", flush_done, done_pend);
    check_eq("resp_valid", resp_valid, resp_pend);
    if (resp_pend) check_eq("resp_data", resp_data, resp_row);
    if (clr_idx >= 0) begin
      check_eq("clr_lrdy",  lookup_ready, 0);
      check_eq("clr_urdy",  upd_ready, 0);
      check_eq("clr_ren",   mem_r_en, 0);
      check_eq("clr_wen",   mem_w_en, 1);
      check_eq("clr_waddr", mem_w_addr, clr_idx);
      check_eq("clr_wdata", mem_w_data, 0);
      check_eq("clr_wmask", mem_w_mask, 8'hFF);
    end else begin
      lk_rdy = !flush_req && !(upd_valid && upd_set == lookup_set);
      up_acc = upd_valid && !flush_req;
      check_eq("lookup_ready", lookup_ready, lk_rdy);
      check_eq("upd_ready", upd_ready, !flush_req);
      check_eq("r_en", mem_r_en, lookup_valid && lk_rdy);
      if (lookup_valid && lk_rdy) check_eq("r_addr", mem_r_addr, lookup_set);
      check_eq("w_en", mem_w_en, up_acc);
      if (up_acc) begin
        check_eq("w_addr", mem_w_addr, upd_set);
        check_eq("w_mask", mem_w_mask, 8'd1 << upd_way);
        check_eq("w_data", mem_w_data, {8{upd_tag}});
      end
    end
  endtask

  task automatic advance();
    lk_acc = 0;
    if (!reset_n) begin
      model_ok = 1; clr_idx = 0; resp_pend = 0; done_pend = 0;
      return;
    end
    if (!model_ok) return;
    if (clr_idx >= 0) begin
      resp_pend = 0;
      for (int w = 0; w < 8; w++) exp_mem[clr_idx][w] = '0;
      done_pend = (clr_idx == 63);
      clr_idx   = (clr_idx == 63) ? -1 : clr_idx + 1;
    end else begin
      lk_acc    = lookup_valid && !flush_req && !(upd_valid && upd_set == lookup_set);
      resp_pend = lk_acc;
      if (lk_acc) resp_row = exp_row(lookup_set);
      if (upd_valid && !flush_req) exp_mem[upd_set][upd_way] = upd_tag;
      done_pend = 0;
      if (flush_req) clr_idx = 0;
    end
  endtask

  always @(negedge clock) begin
    if (model_ok) check_cycle();
    if (resp_valid) last_resp = resp_data;
    advance();
  end

  task automatic next();
    @(posedge clock); #1;
  endtask

  task automatic wait_clear_len(input string tag);
    int n = 0;
    while (!flush_done && n < 200) begin next(); n++; end
    check_eq(tag, n, 64);
  endtask

  task automatic do_lookup(input logic [5:0] s, output logic [183:0] r);
    bit ok = 0;
    last_resp = '1;
    lookup_valid = 1; lookup_set = s;
    for (int i = 0; i < 100 && !ok; i++) begin next(); ok = lk_acc; end
    lookup_valid = 0;
    if (!ok) check_eq("lookup_timeout", 0, 1);
    next();
    r = last_resp;
  endtask

  task automatic do_update(input logic [5:0] s, input logic [2:0] w, input logic [22:0] t);
    upd_valid = 1; upd_set = s; upd_way = w; upd_tag = t;
    next();
    upd_valid = 0;
  endtask

  logic [183:0] r;
  int busy_cnt, done_cnt;

  initial begin
    reset_n = 0; lookup_valid = 0; lookup_set = 0; upd_valid = 0;
    upd_set = 0; upd_way = 0; upd_tag = 0; flush_req = 0;
    repeat (3) next();
    reset_n = 1;
    #1 check_eq("clr0_addr", mem_w_addr, 0);
    wait_clear_len("reset_clear_len");

    do_lookup(6'd37, r);
    check_eq("lookup37", r, 184'h0);

    do_update(6'd5, 3'd3, 23'h1ABCDE);
    do_lookup(6'd5, r);
    check_eq("masked_upd", r, 184'h1ABCDE << 69);

    // Same-set hazard
    upd_valid = 1; upd_set = 9; upd_way = 0; upd_tag = 23'h7FFFFF;
    lookup_valid = 1; lookup_set = 9;
    #1 check_eq("haz_lrdy0", lookup_ready, 0);
    next();
    upd_valid = 0;
    #1 check_eq("haz_lrdy1", lookup_ready, 1);
    last_resp = '1;
    next();
    lookup_valid = 0;
    next();
    check_eq("haz_data", last_resp, 184'h7FFFFF);

    // Parallel access to different sets
    do_update(6'd4, 3'd6, 23'h055AA5);
    upd_valid = 1; upd_set = 2; upd_way = 1; upd_tag = 23'h123456;
    lookup_valid = 1; lookup_set = 4;
    #1 check_eq("par_lrdy", lookup_ready, 1);
    check_eq("par_urdy", upd_ready, 1);
    last_resp = '1;
    next();
    upd_valid = 0; lookup_valid = 0;
    next();
    check_eq("par_data", last_resp, 184'h055AA5 << 138);

    // Flush with a second request ignored during the clear
    for (int s = 0; s < 4; s++) do_update(6'(s), 3'(s + 2), 23'(s * 4099 + 77));
    flush_req = 1;
    next();
    flush_req = 0;
    busy_cnt = 0; done_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      flush_req = (i == 9);
      busy_cnt += int'(busy);
      done_cnt += int'(flush_done);
      next();
    end
    flush_req = 0;
    check_eq("flush_busy_len", busy_cnt, 64);
    check_eq("flush_done_cnt", done_cnt, 1);
    do_lookup(6'd3, r);
    check_eq("flush_set3", r, 184'h0);

    // Reset in the middle of a clear
    flush_req = 1;
    next();
    flush_req = 0;
    repeat (20) next();
    check_eq("mid_cnt20", mem_w_addr, 20);
    reset_n = 0;
    next();
    check_eq("mid_rst_busy", busy, 1);
    check_eq("mid_rst_wen", mem_w_en, 0);
    next();
    reset_n = 1;
    #1 check_eq("mid_restart_addr", mem_w_addr, 0);
    wait_clear_len("mid_clear_len");

    // Randomized traffic against the model
    for (int i = 0; i < 2500; i++) begin
      if (!lookup_valid || lk_acc) begin
        lookup_valid = 1'($urandom_range(0, 1));
        lookup_set   = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'($urandom_range(0, 7));
      end
      upd_valid = 1'($urandom_range(0, 1));
      upd_set   = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'($urandom_range(0, 7));
      upd_way   = 3'($urandom);
      upd_tag   = 23'($urandom);
      flush_req = ($urandom_range(0, 299) == 0);
      next();
    end
    lookup_valid = 0; upd_valid = 0; flush_req = 0;
    repeat (3) next();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
